// File: rtl/inst_fetch_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_pkg
// Shared definitions for the instruction fetch unit: bus widths, chip-enable
// levels, the zero word, the reset fetch address and the fetch-buffer entry.
// Optional feature macro: IF_ALIGN_CHECK_EN (adds an address-error bit to
// every buffered entry).
// -----------------------------------------------------------------------------
package inst_fetch_pkg;

   localparam int          InstAddrBus = 32;
   localparam int          InstBus     = 32;
   localparam logic [31:0] ZeroWord    = 32'h0000_0000;
   localparam logic        ChipEnable  = 1'b1;
   localparam logic        ChipDisable = 1'b0;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   // One fetch-buffer entry; adel only exists when alignment checking is built in
   typedef struct packed {
`ifdef IF_ALIGN_CHECK_EN
      logic                 adel;
`endif
      logic [InstAddrBus-1:0] pc;
      logic [InstBus-1:0]     inst;
   } fetch_entry_t;

   localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

   // Clears the two byte-offset bits so a redirect target is word aligned
   function automatic logic [31:0] align_pc(input logic [31:0] p);
      return p & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_if
// Groups the ROM read bus and the fetch->decode handshake.
//   ROM bus : ce (chip enable), addr (byte address), inst (read data, same cycle)
//   Decode  : id_valid_o, id_pc_o, id_inst_o, id_adel_o towards decode,
//             id_ready_i back from decode
// master = fetch unit, slave = ROM + decode side.
// -----------------------------------------------------------------------------
interface inst_fetch_if;
   import inst_fetch_pkg::*;

   logic                   ce;
   logic [InstAddrBus-1:0] addr;
   logic [InstBus-1:0]     inst;
   logic                   id_ready_i;
   logic                   id_valid_o;
   logic [InstAddrBus-1:0] id_pc_o;
   logic [InstBus-1:0]     id_inst_o;
   logic                   id_adel_o;

   modport master (
      output ce, addr, id_valid_o, id_pc_o, id_inst_o, id_adel_o,
      input  inst, id_ready_i
   );

   modport slave (
      input  ce, addr, id_valid_o, id_pc_o, id_inst_o, id_adel_o,
      output inst, id_ready_i
   );
endinterface

// File: rtl/inst_fetch_fifo.sv
// -----------------------------------------------------------------------------
// inst_fifo
// Synchronous FIFO with a synchronous flush, used as the fetch buffer.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush_i    : empties the FIFO at the next edge (wins over push/pop)
//   push_i     : write wdata_i at the tail (caller guarantees not full or popping)
//   pop_i      : drop the head entry (caller guarantees not empty)
//   rdata_o    : head entry, all zeros while empty
//   empty_o, full_o : occupancy flags
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module inst_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             empty_o,
   output logic             full_o
);
   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [PW:0]      count_q;
   logic [WIDTH-1:0] mem_q [DEPTH];

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {(PW+1){1'b0}};
      end else if (flush_i) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {(PW+1){1'b0}};
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + (PW+1)'(1);
            2'b01:   count_q <= count_q - (PW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage; contents are never observed while empty, so no reset
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign empty_o = (count_q == {(PW+1){1'b0}});
   assign full_o  = (count_q == (PW+1)'(DEPTH));
   assign rdata_o = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];
endmodule

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction fetch initiator. Reads the combinational instruction ROM at pc,
// buffers {pc, inst} in inst_fifo and hands entries to decode.
//   clk, rst         : clock, asynchronous active-low reset
//   bus (master)     : ce/addr/inst ROM bus, id_* decode handshake
//   redirect_i       : flush the buffer and restart fetch at redirect_pc_i
//   redirect_pc_i    : new fetch address
// Optional feature macro: IF_ALIGN_CHECK_EN. When defined, a misaligned
// redirect halts fetch after queuing one address-error entry (adel=1);
// otherwise the redirect target is forced word aligned.
// -----------------------------------------------------------------------------
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF
) (
   input  logic               clk,
   input  logic               rst,
   inst_fetch_if.master       bus,
   input  logic               redirect_i,
   input  logic [31:0]        redirect_pc_i
);
   logic         en_q;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  redir_pc_s;
   logic         push_s, pop_s, ce_s, id_valid_s;
   logic         empty_s, full_s;
   logic         halt_s;
   fetch_entry_t wr_entry_s, rd_entry_s;
   logic [FETCH_ENTRY_W-1:0] rdata_s;

`ifdef IF_ALIGN_CHECK_EN
   logic halt_q, halt_d;
   logic adel_sent_q, adel_sent_d;
`endif

   // Fetch enable rises one edge after reset release, so the release cycle never accesses ROM
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en_q <= 1'b0;
         pc_q <= RESET_PC;
      end else begin
         en_q <= 1'b1;
         pc_q <= pc_d;
      end
   end

`ifdef IF_ALIGN_CHECK_EN
   // Halt state for misaligned redirects
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         halt_q      <= 1'b0;
         adel_sent_q <= 1'b0;
      end else begin
         halt_q      <= halt_d;
         adel_sent_q <= adel_sent_d;
      end
   end
`endif

   // Push/pop arbitration, ROM enable and next pc; redirect overrides everything
   always_comb begin
      halt_s     = 1'b0;
      redir_pc_s = align_pc(redirect_pc_i);
`ifdef IF_ALIGN_CHECK_EN
      redir_pc_s  = redirect_pc_i;
      halt_s      = halt_q;
      halt_d      = halt_q;
      adel_sent_d = adel_sent_q;
`endif
      id_valid_s = !empty_s && !redirect_i;
      pop_s      = id_valid_s && bus.id_ready_i;
      push_s     = en_q && !redirect_i && (!full_s || pop_s);
`ifdef IF_ALIGN_CHECK_EN
      // Once the single error entry is queued, a halted unit stays idle
      if (halt_q && adel_sent_q) begin
         push_s = 1'b0;
      end else begin
         push_s = push_s;
      end
      if (redirect_i) begin
         halt_d      = (redirect_pc_i[1:0] != 2'b00);
         adel_sent_d = 1'b0;
      end else if (push_s && halt_q) begin
         adel_sent_d = 1'b1;
      end else begin
         adel_sent_d = adel_sent_q;
      end
`endif
      // The error entry is synthesised locally, so the ROM is not enabled for it
      ce_s = push_s && !halt_s;

      wr_entry_s.pc   = pc_q;
      wr_entry_s.inst = halt_s ? ZeroWord : bus.inst;
`ifdef IF_ALIGN_CHECK_EN
      wr_entry_s.adel = halt_s;
`endif

      if (redirect_i) begin
         pc_d = redir_pc_s;
      end else if (ce_s) begin
         pc_d = pc_q + 32'd4;
      end else begin
         pc_d = pc_q;
      end
   end

   inst_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (FETCH_ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .flush_i (redirect_i),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .wdata_i (wr_entry_s),
      .rdata_o (rdata_s),
      .empty_o (empty_s),
      .full_o  (full_s)
   );

   assign rd_entry_s     = fetch_entry_t'(rdata_s);
   assign bus.ce         = ce_s ? ChipEnable : ChipDisable;
   assign bus.addr       = pc_q;
   assign bus.id_valid_o = id_valid_s;
   assign bus.id_pc_o    = rd_entry_s.pc;
   assign bus.id_inst_o  = rd_entry_s.inst;
`ifdef IF_ALIGN_CHECK_EN
   assign bus.id_adel_o  = rd_entry_s.adel;
`else
   assign bus.id_adel_o  = 1'b0;
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
// Directed bench for inst_fetch with a combinational ROM model where the word
// at byte address a is 32'h10000000 + a/4. Honours IF_ALIGN_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_inst_fetch;
   logic        clk;
   logic        rst;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   int          tests;
   int          failed;
   int          pushes;

   inst_fetch_if bus ();

   inst_fetch #(
      .FIFO_DEPTH (4),
      .RESET_PC   (32'h0000_0000)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i)
   );

   // ROM model: word index plus a fixed tag
   assign bus.inst = 32'h1000_0000 + {2'b00, bus.addr[31:2]};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests = 0; failed = 0; pushes = 0;
      rst = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; bus.id_ready_i = 1'b1;

      // 1. reset values, startup latency, streaming
      #2;
      chk("rst_ce",    {31'd0, bus.ce},         32'h0);
      chk("rst_addr",  bus.addr,                32'h0);
      chk("rst_valid", {31'd0, bus.id_valid_o}, 32'h0);
      chk("rst_pc",    bus.id_pc_o,             32'h0);
      chk("rst_inst",  bus.id_inst_o,           32'h0);
      chk("rst_adel",  {31'd0, bus.id_adel_o},  32'h0);
      tick(); tick();
      rst = 1'b1;
      #1 chk("rel_ce", {31'd0, bus.ce}, 32'h0);
      tick();
      #1 chk("st_ce",    {31'd0, bus.ce},         32'h1);
      chk("st_addr",     bus.addr,                32'h0);
      chk("st_valid",    {31'd0, bus.id_valid_o}, 32'h0);
      tick();
      #1 chk("first_valid", {31'd0, bus.id_valid_o}, 32'h1);
      chk("first_pc",   bus.id_pc_o,   32'h0);
      chk("first_inst", bus.id_inst_o, 32'h1000_0000);
      for (int k = 1; k <= 4; k++) begin
         tick();
         #1 chk("stream_pc", bus.id_pc_o,   32'(4 * k));
         chk("stream_inst",  bus.id_inst_o, 32'h1000_0000 + 32'(k));
      end

      // 2. fill while stalled, then drain at full rate
      rst = 1'b0;
      #1 tick();
      bus.id_ready_i = 1'b0;
      rst = 1'b1;
      #1 chk("fill_rel_ce", {31'd0, bus.ce}, 32'h0);
      for (int k = 0; k < 10; k++) begin
         tick();
         #1 if (bus.ce === 1'b1) pushes++;
      end
      chk("fill_pushes", 32'(pushes), 32'd4);
      chk("full_ce",    {31'd0, bus.ce},         32'h0);
      chk("full_addr",  bus.addr,                32'h10);
      chk("full_valid", {31'd0, bus.id_valid_o}, 32'h1);
      bus.id_ready_i = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1 chk("drain_pc", bus.id_pc_o, 32'(4 * k));
         chk("drain_ce",    {31'd0, bus.ce}, 32'h1);
         chk("drain_addr",  bus.addr, 32'h10 + 32'(4 * k));
         tick();
      end

      // 3. redirect with three entries buffered
      bus.id_ready_i = 1'b0;
      redirect_i = 1'b1; redirect_pc_i = 32'h100;
      #1 chk("redir1_ce", {31'd0, bus.ce}, 32'h0);
      tick();
      redirect_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1 chk("three_addr", bus.addr, 32'h100 + 32'(4 * k));
         tick();
      end
      bus.id_ready_i = 1'b1;
      redirect_i = 1'b1; redirect_pc_i = 32'h200;
      #1 chk("redir2_ce", {31'd0, bus.ce},         32'h0);
      chk("redir2_valid", {31'd0, bus.id_valid_o}, 32'h0);
      tick();
      redirect_i = 1'b0;
      #1 chk("post_redir_ce", {31'd0, bus.ce}, 32'h1);
      chk("post_redir_addr",  bus.addr,        32'h200);
      chk("post_redir_valid", {31'd0, bus.id_valid_o}, 32'h0);
      tick();
      #1 chk("redir_head_pc", bus.id_pc_o,   32'h200);
      chk("redir_head_inst",  bus.id_inst_o, 32'h1000_0080);

      // 4. pc wraps modulo 2^32
      redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
      #1 tick();
      redirect_i = 1'b0;
      #1 chk("wrap_addr", bus.addr, 32'hFFFF_FFF8);
      tick();
      #1 chk("wrap_pc0", bus.id_pc_o, 32'hFFFF_FFF8);
      tick();
      #1 chk("wrap_pc1", bus.id_pc_o, 32'hFFFF_FFFC);
      tick();
      #1 chk("wrap_pc2", bus.id_pc_o, 32'h0000_0000);
      chk("wrap_inst2",  bus.id_inst_o, 32'h1000_0000);

      // back-to-back redirects: last one wins
      redirect_i = 1'b1; redirect_pc_i = 32'h500;
      #1 tick();
      redirect_pc_i = 32'h600;
      #1 tick();
      redirect_i = 1'b0;
      #1 chk("b2b_addr", bus.addr, 32'h600);
      chk("b2b_valid", {31'd0, bus.id_valid_o}, 32'h0);

      // 5. asynchronous reset mid-operation
      tick();
      bus.id_ready_i = 1'b0;
      redirect_i = 1'b1; redirect_pc_i = 32'h40;
      #1 tick();
      redirect_i = 1'b0;
      #1 tick();
      #1 tick();
      #1 chk("pre_rst_valid", {31'd0, bus.id_valid_o}, 32'h1);
      chk("pre_rst_ce", {31'd0, bus.ce}, 32'h1);
      #2 rst = 1'b0;
      #1 chk("arst_valid", {31'd0, bus.id_valid_o}, 32'h0);
      chk("arst_ce",   {31'd0, bus.ce}, 32'h0);
      chk("arst_pc",   bus.id_pc_o,     32'h0);
      chk("arst_addr", bus.addr,        32'h0);
      bus.id_ready_i = 1'b1;
      tick(); tick();
      rst = 1'b1;
      #1 chk("rerel_ce", {31'd0, bus.ce}, 32'h0);
      tick();
      #1 chk("restart_addr", bus.addr, 32'h0);
      chk("restart_ce", {31'd0, bus.ce}, 32'h1);
      tick();
      #1 chk("restart_pc", bus.id_pc_o, 32'h0);

      // 6. misaligned redirect
      bus.id_ready_i = 1'b0;
      redirect_i = 1'b1; redirect_pc_i = 32'h202;
      #1 tick();
      redirect_i = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
      #1 chk("halt_ce0", {31'd0, bus.ce}, 32'h0);
      chk("halt_valid0", {31'd0, bus.id_valid_o}, 32'h0);
      tick();
      #1 chk("adel_valid", {31'd0, bus.id_valid_o}, 32'h1);
      chk("adel_pc",   bus.id_pc_o,            32'h202);
      chk("adel_inst", bus.id_inst_o,          32'h0);
      chk("adel_bit",  {31'd0, bus.id_adel_o}, 32'h1);
      chk("halt_ce1",  {31'd0, bus.ce},        32'h0);
      tick(); tick();
      #1 chk("halt_ce2", {31'd0, bus.ce}, 32'h0);
      bus.id_ready_i = 1'b1;
      #1 tick();
      #1 chk("halt_drained", {31'd0, bus.id_valid_o}, 32'h0);
      chk("halt_ce3", {31'd0, bus.ce}, 32'h0);
`else
      #1 chk("align_ce",  {31'd0, bus.ce}, 32'h1);
      chk("align_addr", bus.addr, 32'h200);
      tick();
      #1 chk("align_pc",  bus.id_pc_o, 32'h200);
      chk("align_adel", {31'd0, bus.id_adel_o}, 32'h0);
`endif
      bus.id_ready_i = 1'b1;
      redirect_i = 1'b1; redirect_pc_i = 32'h300;
      #1 tick();
      redirect_i = 1'b0;
      #1 chk("resume_ce", {31'd0, bus.ce}, 32'h1);
      chk("resume_addr",  bus.addr, 32'h300);
      tick();
      #1 chk("resume_pc", bus.id_pc_o, 32'h300);
      chk("resume_adel",  {31'd0, bus.id_adel_o}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
